// File: rtl/gp_arbiter.sv
// Round-robin arbiter sharing the graphics painter between NUM_REQ drawing clients.
// Optional coordinate clipping and out-of-screen command dropping: define GP_ARB_CLIP_EN.
module gp_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SCR_W   = 640,
    parameter int unsigned SCR_H   = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_opcode,
    input  logic [NUM_REQ*10-1:0] req_tl_x,
    input  logic [NUM_REQ*9-1:0]  req_tl_y,
    input  logic [NUM_REQ*10-1:0] req_br_x,
    input  logic [NUM_REQ*9-1:0]  req_br_y,
    input  logic [NUM_REQ*12-1:0] req_arg,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    output logic [2:0]            grant_id,
    input  logic                  gp_finish,
    output logic                  gp_en,
    output logic                  gp_opcode,
    output logic [9:0]            gp_tl_x,
    output logic [8:0]            gp_tl_y,
    output logic [9:0]            gp_br_x,
    output logic [8:0]            gp_br_y,
    output logic [11:0]           gp_arg
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || SCR_W > 1024 || SCR_H > 512 || SCR_W < 1 || SCR_H < 1)
    begin : g_bad_cfg
        $error("gp_arbiter: unsupported parameter set");
    end

`ifdef GP_ARB_CLIP_EN
    localparam logic [9:0] MaxX = 10'(SCR_W - 1);
    localparam logic [8:0] MaxY = 9'(SCR_H - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StRelease, StDrop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StIssue, StRelease} state_e;
`endif

    state_e       state;
    logic [2:0]   rr_ptr;

    logic         win_found;
    logic [2:0]   win_idx;
    logic         win_opcode;
    logic [9:0]   win_tl_x;
    logic [8:0]   win_tl_y;
    logic [9:0]   win_br_x;
    logic [8:0]   win_br_y;
    logic [11:0]  win_arg;
    logic         win_drop;

    logic [NUM_REQ-1:0] owner_onehot;
    logic [2:0]         ptr_next;

    // Scan from rr_ptr upward with wrap; the first requester found wins.
    always_comb begin
        int unsigned      cand;
        logic [IdxW-1:0]  ci;
        win_found  = 1'b0;
        win_idx    = '0;
        win_opcode = 1'b0;
        win_tl_x   = '0;
        win_tl_y   = '0;
        win_br_x   = '0;
        win_br_y   = '0;
        win_arg    = '0;
        cand       = 0;
        ci         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            ci = cand[IdxW-1:0];
            if (!win_found && req[ci]) begin
                win_found  = 1'b1;
                win_idx    = 3'(cand);
                win_opcode = req_opcode[ci];
                win_tl_x   = req_tl_x[10*ci +: 10];
                win_tl_y   = req_tl_y[9*ci +: 9];
                win_br_x   = req_br_x[10*ci +: 10];
                win_br_y   = req_br_y[9*ci +: 9];
                win_arg    = req_arg[12*ci +: 12];
            end
        end
`ifdef GP_ARB_CLIP_EN
        if (win_br_x > MaxX) win_br_x = MaxX;
        if (win_br_y > MaxY) win_br_y = MaxY;
        win_drop = (win_tl_x > MaxX) || (win_tl_y > MaxY);
`else
        win_drop = 1'b0;
`endif
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            owner_onehot[i] = (grant_id == 3'(i));
        end
    end

    assign ptr_next = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
    assign busy     = (state != StIdle);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            rr_ptr    <= '0;
            done      <= '0;
            grant_id  <= '0;
            gp_en     <= 1'b0;
            gp_opcode <= 1'b0;
            gp_tl_x   <= '0;
            gp_tl_y   <= '0;
            gp_br_x   <= '0;
            gp_br_y   <= '0;
            gp_arg    <= '0;
        end else begin
            done <= '0;
            unique case (state)
                StIdle: begin
                    // A painter still holding finish from a previous command blocks new grants.
                    if (win_found && !gp_finish) begin
                        grant_id <= win_idx;
                        if (win_drop) begin
`ifdef GP_ARB_CLIP_EN
                            state <= StDrop;
`endif
                        end else begin
                            gp_en     <= 1'b1;
                            gp_opcode <= win_opcode;
                            gp_tl_x   <= win_tl_x;
                            gp_tl_y   <= win_tl_y;
                            gp_br_x   <= win_br_x;
                            gp_br_y   <= win_br_y;
                            gp_arg    <= win_arg;
                            state     <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (gp_finish) begin
                        gp_en <= 1'b0;
                        state <= StRelease;
                    end
                end
                StRelease: begin
                    if (!gp_finish) begin
                        done   <= owner_onehot;
                        rr_ptr <= ptr_next;
                        state  <= StIdle;
                    end
                end
`ifdef GP_ARB_CLIP_EN
                StDrop: begin
                    done   <= owner_onehot;
                    rr_ptr <= ptr_next;
                    state  <= StIdle;
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule
